// File: rtl/amm_word_ram_if.sv
// amm_word_ram_if: 16-bit word-wide Avalon-MM bus bundle with master/slave views
interface avalon_mm_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [1:0]  byteenable;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        readdatavalid;
   logic        waitrequest;
   modport master (output address, read, write, byteenable, writedata,
                   input readdata, readdatavalid, waitrequest);
   modport slave  (input address, read, write, byteenable, writedata,
                   output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/amm_word_ram.sv
// amm_word_ram: word-wide Avalon-MM RAM with wait states and fixed read latency; AMM_WORD_RAM_BOUNDS_CHECK_EN adds bounds checking and err_o
module amm_word_ram #(
   parameter int          DEPTH        = 1024,
   parameter int          WAIT_STATES  = 1,
   parameter int          READ_LATENCY = 2,
   parameter logic [15:0] INIT_VAL     = 16'h0000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   avalon_mm_if.slave  amm_if,
   output logic        err_o
);
   localparam int AW = $clog2(DEPTH);
   // the IDLE cycle that sees the command already counts as the first wait cycle
   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 1 ? WAIT_STATES - 2 : 0);

   typedef enum logic [1:0] {IDLE, WAIT, ACCEPT} state_t;

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic            cmd, acc, wr_en, rd_en, oob;
   logic [AW-1:0]   idx;
   logic [15:0]     mem [DEPTH] = '{default: INIT_VAL};
   logic [READ_LATENCY-1:0] vld;
   logic [15:0]     dat [READ_LATENCY];

   assign cmd   = amm_if.read | amm_if.write;
   assign acc   = cmd & ~amm_if.waitrequest;
   assign idx   = amm_if.address[AW-1:0];
   assign wr_en = acc & amm_if.write & ~oob;
   assign rd_en = acc & amm_if.read & ~amm_if.write;

   // state and wait counter registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next state: wait out the configured cycles, then one accept cycle
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (cmd && WAIT_STATES > 0) begin
            state_nxt = WAIT_STATES > 1 ? WAIT : ACCEPT;
            cnt_nxt   = CNT_INIT;
         end
         WAIT: begin
            state_nxt = cnt == 4'd0 ? ACCEPT : WAIT;
            cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // waitrequest decoded from state only; forced high while in reset
   always_comb amm_if.waitrequest = !rst_n_i || (state == IDLE ? WAIT_STATES != 0 : state != ACCEPT);

   // byte-lane writes; contents survive reset
   always_ff @(posedge clk_i) begin
      if (wr_en)
         for (int i = 0; i < 2; i++)
            if (amm_if.byteenable[i]) mem[idx][8*i +: 8] <= amm_if.writedata[8*i +: 8];
   end

   // read data/valid shift pipeline, flushed by reset
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vld <= '0;
         for (int i = 0; i < READ_LATENCY; i++) dat[i] <= '0;
      end else begin
         vld[0] <= rd_en;
         dat[0] <= oob ? 16'hBAD0 : mem[idx];
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
      end
   end

   assign amm_if.readdatavalid = vld[READ_LATENCY-1];
   assign amm_if.readdata      = vld[READ_LATENCY-1] ? dat[READ_LATENCY-1] : '0;

`ifdef AMM_WORD_RAM_BOUNDS_CHECK_EN
   assign oob = |amm_if.address[31:AW];

   // sticky error: out-of-range access, read+write together, or command dropped while waiting
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         err_o <= 1'b0;
      else if ((acc && (oob || (amm_if.read && amm_if.write))) || ((state == WAIT || state == ACCEPT) && !cmd))
         err_o <= 1'b1;
   end
`else
   assign oob   = 1'b0;
   assign err_o = 1'b0;
`endif
endmodule
